// File: rtl/booth_mul_32.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_32
// Purpose  : Pipelined 32x32 signed multiplier using radix-4 (bit-pair) Booth
//            recoding of b. Produces the full 64-bit two's-complement product
//            two rising edges after the operands are sampled. It accepts one
//            operand pair per cycle.
// Ports    : clk       - system clock, rising edge active
//            rst_n     - asynchronous active-low reset
//            in_valid  - a/b valid this cycle
//            a         - signed multiplicand
//            b         - signed multiplier (Booth-recoded)
//            out_valid - z holds a new product this cycle
//            z         - signed 64-bit product a*b (held while out_valid=0)
// Revision : 1.0  initial release
// ============================================================================
module booth_mul_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [63:0] z
);

  localparam int c_NUM_DIGITS = 16;

  // Stage 1 registers
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        v1_q, v1_d;

  // Output registers
  logic [63:0] z_q, z_d;
  logic        out_valid_q, out_valid_d;

  // Stage 2 combinational
  logic [32:0] w_bx;                     // b_q with the implicit b[-1]=0 appended
  logic [63:0] w_pp [c_NUM_DIGITS];      // aligned partial products
  logic [63:0] w_sum;

  assign w_bx = {b_q, 1'b0};

  // One Booth digit per bit pair of b_q.
  generate
    for (genvar i = 0; i < c_NUM_DIGITS; i++) begin : g_pp
      logic [2:0]  w_trip;
      logic [32:0] w_mag;   // |multiple| of a, 33 bits so 2a cannot overflow
      logic        w_neg;
      logic [63:0] w_ext;
      logic [63:0] w_sgn;

      assign w_trip = w_bx[2*i+2 -: 3];

      always_comb begin
        w_mag = 33'd0;
        w_neg = 1'b0;
        case (w_trip)
          3'b001, 3'b010: w_mag = {a_q[31], a_q};
          3'b011:         w_mag = {a_q, 1'b0};
          3'b100: begin
            w_mag = {a_q, 1'b0};
            w_neg = 1'b1;
          end
          3'b101, 3'b110: begin
            w_mag = {a_q[31], a_q};
            w_neg = 1'b1;
          end
          default:        w_mag = 33'd0;  // 000, 111 -> digit 0
        endcase
      end

      assign w_ext   = {{31{w_mag[32]}}, w_mag};
      // Negate at full 64-bit width so -(-2^32) style cases wrap correctly.
      assign w_sgn   = w_neg ? (~w_ext + 64'd1) : w_ext;
      assign w_pp[i] = w_sgn << (2 * i);
    end
  endgenerate

  // Sum of all partial products modulo 2^64; synthesis is free to restructure
  // this chain into a tree / CSA array.
  always_comb begin
    w_sum = 64'd0;
    for (int i = 0; i < c_NUM_DIGITS; i++) begin
      w_sum = w_sum + w_pp[i];
    end
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    v1_d        = in_valid;
    out_valid_d = v1_q;
    if (in_valid) begin
      a_d = a;
      b_d = b;
    end
    if (v1_q) begin
      z_d = w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      v1_q        <= 1'b0;
      z_q         <= 64'd0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z         = z_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_32
// Purpose  : Self-checking bench for booth_mul_32. A behavioural model built
//            from a plain 64-bit signed multiply and a two-cycle latency is
//            compared against the DUT every cycle; directed vectors pin the
//            model with literal products.
// Revision : 1.0  initial release
// ============================================================================
module tb_booth_mul_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [63:0] z;

  int checks;
  int failures;

  booth_mul_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .z        (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: product computed by the simulator's own multiply,
  // delayed two edges; z holds the last valid product.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    return sx * sy;
  endfunction

  logic        m_v1;
  logic [63:0] m_p1;
  logic        m_ov;
  logic [63:0] m_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v1 <= 1'b0;
      m_p1 <= 64'd0;
      m_ov <= 1'b0;
      m_z  <= 64'd0;
    end else begin
      m_v1 <= in_valid;
      m_p1 <= ref_mul(a, b);
      m_ov <= m_v1;
      if (m_v1) m_z <= m_p1;
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_ov) begin
      failures++;
      $display("FAIL out_valid_cycle t=%0t got=%b exp=%b", $time, out_valid, m_ov);
    end
    checks++;
    if (z !== m_z) begin
      failures++;
      $display("FAIL z_cycle t=%0t got=%h exp=%h", $time, z, m_z);
    end
  end

  task automatic check64(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One isolated operation; checks DUT and model against a literal product
  // exactly two edges after the sample.
  task automatic directed(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [63:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    check64({nm, "_early_valid"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check64({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
    check64({nm, "_z"}, z, exp);
    check64({nm, "_model"}, m_z, exp);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 32'd0;
    b        = 32'd0;

    #2;
    check64("reset_z", z, 64'd0);
    check64("reset_valid", {63'd0, out_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    directed("small1", 32'd15, 32'd10, 64'd150);
    directed("small2", 32'h73, 32'hF2, 64'h6CB6);
    directed("mix1",   32'd12, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFC4);
    directed("mix2",   32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    directed("negneg", 32'hFFFF_FFF7, 32'hFFFF_FFF5, 64'd99);
    directed("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    directed("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    directed("m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // Streaming with one bubble; per-cycle compare covers order and hold.
    sa = '{32'd15, 32'h73, 32'd12, 32'hFFFF_FFF9, 32'hFFFF_FFF7,
           32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    sb = '{32'd10, 32'hF2, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFF5,
           32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = sa[i]; b = sb[i];
      @(posedge clk); #1;
      if (i == 3) begin
        in_valid = 1'b0; a = $urandom; b = $urandom;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Random stream.
    for (int i = 0; i < 12000; i++) begin
      #1;
      in_valid = ($urandom_range(0, 9) < 8);
      a = $urandom;
      b = $urandom;
      @(posedge clk);
    end
    #1;

    // Asynchronous reset mid-stream with valid data in flight.
    in_valid = 1'b1; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd5;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check64("async_reset_z", z, 64'd0);
    check64("async_reset_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check64("post_reset_no_stale", {63'd0, out_valid}, 64'd0);

    directed("after_reset", 32'h0001_0000, 32'hFFFF_0000, 64'hFFFF_FFFF_0000_0000);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
